// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared by the fetch stage and its neighbours.
//   - opcode constants and special instruction words
//   - bit positions of the decoded instruction fields
//   - fetch state enumeration
package riscv_pkg;

  localparam logic [6:0]  OP_R_TYPE   = 7'b0110011;
  localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;
  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;

  // Field positions (LSB) within a 32-bit instruction word
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNC3_LSB  = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNC7_LSB  = 25;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// instr_mem: synchronous instruction RAM, one read port and one write port.
//   clk, rst : clock; rst clears only the read-data register
//   re/raddr : read enable and word address; rdata valid the next cycle
//   we/waddr/wdata : load write port
//   rdata    : registered read data; holds when re is low
// A read and a write to the same word in one cycle return the old word.
module instr_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage owning the PC and the instruction memory.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : freeze presented instruction and fetch address
//   redirect_valid/pc : branch/jump target (low two bits ignored)
//   imem_we/waddr/wdata : program-load port
//   instr_valid, pc, instr : presented instruction
//   opcode, rd, func3, rs1, rs2, func7 : slices of instr
//   halted            : unit is in S_HALT (ECALL or fetch out of memory)
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic                          instr_valid,
  output logic [31:0]                   pc,
  output logic [31:0]                   instr,
  output logic [6:0]                    opcode,
  output logic [4:0]                    rd,
  output logic [2:0]                    func3,
  output logic [4:0]                    rs1,
  output logic [4:0]                    rs2,
  output logic [6:0]                    func7,
  output logic                          halted
);

  localparam int unsigned AW         = $clog2(IMEM_DEPTH);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_DEPTH * 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic         mem_re;
  logic [31:0]  mem_rdata;
  logic         ecall_seen;
  logic         out_of_range;

  // The RAM's read register doubles as the presented-instruction register,
  // so the read enable is the "advance" strobe.
  instr_mem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .rst   (rst),
    .re    (mem_re),
    .raddr (fetch_pc_q[AW+1:2]),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .rdata (mem_rdata)
  );

  assign ecall_seen   = valid_q && (mem_rdata == INSTR_ECALL) && !stall;
  assign out_of_range = (fetch_pc_q >= IMEM_BYTES);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    mem_re     = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      valid_d    = 1'b0;
      state_d    = S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (stall) begin
            // hold everything
          end else if (ecall_seen || out_of_range) begin
            valid_d = 1'b0;
            state_d = S_HALT;
          end else begin
            mem_re     = 1'b1;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            valid_d    = 1'b1;
          end
        end
        S_HALT: valid_d = 1'b0;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign instr       = mem_rdata;
  assign opcode      = mem_rdata[OPCODE_LSB +: 7];
  assign rd          = mem_rdata[RD_LSB     +: 5];
  assign func3       = mem_rdata[FUNC3_LSB  +: 3];
  assign rs1         = mem_rdata[RS1_LSB    +: 5];
  assign rs2         = mem_rdata[RS2_LSB    +: 5];
  assign func7       = mem_rdata[FUNC7_LSB  +: 7];
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed test-plan scenarios plus randomized
// stall/redirect/load/reset traffic against a behavioural fetch model,
// and a small-memory instance for the out-of-range halt.
module tb_instr_fetch_unit;

  localparam logic [31:0] ADD_W   = 32'h002081B3;
  localparam logic [31:0] SUB_W   = 32'h402081B3;
  localparam logic [31:0] ECALL_W = 32'h0000_0073;
  localparam logic [31:0] NOP_W   = 32'h0000_0013;
  localparam logic [31:0] ADDI_W  = 32'h00500093;

  logic        clk;
  logic        rst, stall, redirect_valid, imem_we;
  logic [31:0] redirect_pc, imem_wdata;
  logic [5:0]  imem_waddr;
  logic        instr_valid, halted;
  logic [31:0] pc, instr;
  logic [6:0]  opcode, func7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  func3;

  logic        s_rst, s_stall, s_redirect_valid, s_imem_we;
  logic [31:0] s_redirect_pc, s_imem_wdata;
  logic [1:0]  s_imem_waddr;
  logic        s_instr_valid, s_halted;
  logic [31:0] s_pc, s_instr;
  logic [6:0]  s_opcode, s_func7;
  logic [4:0]  s_rd, s_rs1, s_rs2;
  logic [2:0]  s_func3;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [31:0] m_mem [64];
  logic [31:0] m_fpc, m_pc, m_instr;
  logic        m_valid, m_halt;

  instr_fetch_unit #(.IMEM_DEPTH(64), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .instr_valid(instr_valid), .pc(pc), .instr(instr),
    .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2),
    .func7(func7), .halted(halted)
  );

  instr_fetch_unit #(.IMEM_DEPTH(4), .RESET_PC(32'h0000_0000)) u_small (
    .clk(clk), .rst(s_rst), .stall(s_stall),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .imem_we(s_imem_we), .imem_waddr(s_imem_waddr), .imem_wdata(s_imem_wdata),
    .instr_valid(s_instr_valid), .pc(s_pc), .instr(s_instr),
    .opcode(s_opcode), .rd(s_rd), .func3(s_func3), .rs1(s_rs1), .rs2(s_rs2),
    .func7(s_func7), .halted(s_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=500000", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, then
  // compare every output one time unit after the clock edge.
  task automatic step(input logic r, input logic st, input logic rv,
                      input logic [31:0] rp, input logic we,
                      input logic [5:0] wa, input logic [31:0] wd);
    rst = r; stall = st; redirect_valid = rv; redirect_pc = rp;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    if (r) begin
      m_fpc = 32'h0; m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (rv) begin
      m_fpc = {rp[31:2], 2'b00}; m_valid = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else if (st) begin
      // frozen
    end else if (m_valid && m_instr == ECALL_W) begin
      m_valid = 1'b0; m_halt = 1'b1;
    end else if (m_fpc >= 32'd256) begin
      m_valid = 1'b0; m_halt = 1'b1;
    end else begin
      m_instr = m_mem[m_fpc[7:2]];
      m_pc    = m_fpc;
      m_valid = 1'b1;
      m_fpc   = m_fpc + 32'd4;
    end
    if (we) m_mem[wa] = wd;  // read-first: write lands after the read
    @(posedge clk);
    #1;
    check("valid",  32'(instr_valid), 32'(m_valid));
    check("halted", 32'(halted),      32'(m_halt));
    check("pc",     pc,               m_pc);
    check("instr",  instr,            m_instr);
    check("fields", {func7, rs2, rs1, func3, rd, opcode}, m_instr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
  endtask

  initial begin
    logic        r, st, rv, we;
    logic [31:0] rp, wd;
    logic [5:0]  wa;

    s_rst = 1'b1; s_stall = 1'b0; s_redirect_valid = 1'b0; s_redirect_pc = '0;
    s_imem_we = 1'b0; s_imem_waddr = '0; s_imem_wdata = '0;

    // Load the whole program while held in reset.
    for (int i = 0; i < 64; i++) begin
      case (i)
        0: wd = ADD_W;
        1: wd = SUB_W;
        2: wd = ECALL_W;
        4: wd = ADDI_W;
        default: wd = NOP_W;
      endcase
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 6'(i), wd);
    end
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_pc", pc, 32'h0);

    // ADD then SUB decode
    idle(1);
    check("c1_pc", pc, 32'h0);
    check("c1_opcode", 32'(opcode), 32'h33);
    check("c1_func3", 32'(func3), 32'h0);
    check("c1_func7", 32'(func7), 32'h0);
    check("c1_rd", 32'(rd), 32'h3);
    idle(1);
    check("c2_pc", pc, 32'h4);
    check("c2_func7", 32'(func7), 32'h20);

    // 3-cycle stall on pc=4
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
      check("stall_pc", pc, 32'h4);
      check("stall_valid", 32'(instr_valid), 32'h1);
    end
    idle(1);
    check("post_stall_pc", pc, 32'h8);
    check("ecall_instr", instr, ECALL_W);

    // ECALL halts; stays halted
    idle(1);
    check("ecall_valid", 32'(instr_valid), 32'h0);
    check("ecall_halted", 32'(halted), 32'h1);
    for (int k = 0; k < 10; k++) begin
      idle(1);
      check("halt_hold", 32'(halted), 32'h1);
    end

    // Redirect to 0 resumes after a bubble
    step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 6'd0, 32'h0);
    check("resume_bubble", 32'(instr_valid), 32'h0);
    idle(1);
    check("resume_pc", pc, 32'h0);
    check("resume_valid", 32'(instr_valid), 32'h1);

    // Redirect to unaligned 0x12 while stalled
    step(1'b0, 1'b1, 1'b1, 32'h12, 1'b0, 6'd0, 32'h0);
    check("redir_bubble", 32'(instr_valid), 32'h0);
    idle(1);
    check("redir_pc", pc, 32'h10);
    check("redir_instr", instr, ADDI_W);

    // Reset mid-stream while pc=8 is presented
    step(1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 6'd0, 32'h0);
    idle(2);
    check("pre_rst_pc", pc, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    check("mid_rst_valid", 32'(instr_valid), 32'h0);
    check("mid_rst_pc", pc, 32'h0);
    idle(1);
    check("after_rst_pc", pc, 32'h0);
    check("after_rst_valid", 32'(instr_valid), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 79) == 0);
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      rp = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 300));
      we = ($urandom_range(0, 2) == 0);
      wa = 6'($urandom_range(0, 63));
      wd = ($urandom_range(0, 7) == 0) ? ECALL_W : $urandom;
      step(r, st, rv, rp, we, wa, wd);
    end

    // Small memory: run off the end and halt
    for (int i = 0; i < 4; i++) begin
      s_imem_we = 1'b1; s_imem_waddr = 2'(i); s_imem_wdata = NOP_W;
      @(posedge clk); #1;
    end
    s_imem_we = 1'b0;
    s_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("small_valid", 32'(s_instr_valid), 32'h1);
      check("small_pc", s_pc, 32'(4 * k));
    end
    @(posedge clk); #1;
    check("small_halt_valid", 32'(s_instr_valid), 32'h0);
    check("small_halted", 32'(s_halted), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("small_hold_valid", 32'(s_instr_valid), 32'h0);
      check("small_hold_pc", s_pc, 32'hC);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that owns the program counter and an internal instruction memory, and presents decoded instruction fields (opcode, func3, func7, rs1, rs2, rd) to the downstream control block and register file. Each cycle it issues one 32-bit instruction with a valid flag. It honours stall and branch/jump redirect requests from later stages, and halts on ECALL or when the fetch address leaves the memory. A load port lets the bench or boot logic write the program.

## Interface
Parameters:
- IMEM_DEPTH, 64: instruction memory depth in 32-bit words; must be a power of two.
- RESET_PC, 32'h0000_0000: first fetch address after reset; word-aligned.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the current outputs and the fetch address.
- redirect_valid  in  1  take a new fetch target this cycle.
- redirect_pc  in  32  target address; bits [1:0] are ignored and treated as 0.
- imem_we  in  1  program-load write enable.
- imem_waddr  in  $clog2(IMEM_DEPTH)  word address for the load write.
- imem_wdata  in  32  load write data.
- instr_valid  out  1  the instruction outputs are meaningful this cycle.
- pc  out  32  address of the presented instruction.
- instr  out  32  raw instruction word.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- func3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- func7  out  7  instr[31:25].
- halted  out  1  the unit is in S_HALT.

## Operation
- States: S_RUN and S_HALT. Reset enters S_RUN.
- Reset values: fetch_pc = RESET_PC; pc = 0; instr = 0; all field outputs = 0; instr_valid = 0; halted = 0. Memory contents are not cleared by reset.
- Fields are pure slices of the registered instr and change only when instr changes.
- Memory read is synchronous with one-cycle latency. A write and a read to the same word in the same cycle return the old data (read-first).
- S_RUN, no stall, no redirect:
  - instr <= mem[fetch_pc[.. :2]], pc <= fetch_pc, instr_valid <= 1.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
- Stall without redirect: fetch_pc, pc, instr and instr_valid all hold.
- Redirect has priority over stall and over halt detection, and is accepted in either state:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; instr_valid <= 0 for one bubble cycle; state <= S_RUN.
  - The instruction already presented in that cycle is discarded.
- Halt on ECALL: instr_valid = 1, instr == 32'h0000_0073 and no stall.
  - Next cycle: instr_valid = 0 and state = S_HALT.
  - The ECALL is presented exactly once.
- Halt on out-of-range fetch: fetch_pc >= IMEM_DEPTH*4 in S_RUN with no stall and no redirect.
  - Next cycle: instr_valid = 0 and state = S_HALT.
  - No out-of-range word is ever presented.
- S_HALT: instr_valid = 0, halted = 1, and pc, instr and fetch_pc hold. Only a redirect or reset leaves S_HALT.
- A reset in mid-operation behaves exactly like power-on reset: the in-flight instruction is dropped and the first valid instruction follows as from reset.

## Timing
- The first valid instruction (mem[RESET_PC>>2]) appears on the first cycle after rst is sampled low.
- Throughput is one instruction per cycle.
- Redirect-to-target latency is 2 cycles: cycle N+1 is the bubble, cycle N+2 presents the target instruction.
- Stall is sampled every cycle. Outputs are frozen for exactly the stalled cycles, and there are no gaps afterwards.
- imem writes take effect for reads on the following cycle.

## Structure
- Shared package riscv_pkg holds:
  - Opcode constants: OP_R_TYPE = 7'b0110011, OP_SYSTEM = 7'b1110011.
  - INSTR_ECALL = 32'h0000_0073.
  - INSTR_NOP = 32'h0000_0013.
  - The field bit-position constants.
  - The fetch state enum {S_RUN, S_HALT}.
- Sub-module instr_mem: single-port-read / single-port-write synchronous RAM of depth IMEM_DEPTH, with read-first behaviour. The PC, state machine and output registers live in the top module.

## Test plan
- Load ADD x3,x1,x2 (32'h002081B3) at word 0 and SUB (32'h402081B3) at word 1, then release reset. Cycle 1: pc=0, opcode=7'b0110011, func3=0, func7=0, rd=3. Cycle 2: pc=4, func7=7'b0100000.
- Stall asserted for 3 cycles while pc=4 is presented. pc, instr and instr_valid hold for those 3 cycles; the next cycle presents pc=8.
- Redirect to 32'h0000_0012 while stalled. Next cycle: instr_valid=0. Following cycle: pc=32'h10 with word 4.
- ECALL at word 2 with no stall. pc=8 is presented once; next cycle instr_valid=0 and halted=1, which stays set for 10 cycles. A redirect to 0 then resumes, with pc=0 valid two cycles later.
- IMEM_DEPTH=4 filled with NOPs and run. pc values 0, 4, 8, C are presented, then halted=1 and no pc=16 is ever presented.
- Assert rst mid-stream at pc=8. The next cycle shows instr_valid=0 and pc=0; the first valid instruction after release is pc=RESET_PC.
